jtag_tap_core: RTL and testbench



---
 rtl/jtag_pkg.sv | 33 +++
 rtl/tap_state_fsm.sv | 48 ++++
 rtl/jtag_tap_core.sv | 128 ++++++++++++
 tb/tb_jtag_tap_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP definitions.
// Contents:
//   tap_state_t   - 4-bit TAP state encoding. Other blocks decode the state
//                   output, so this encoding is fixed.
//   DEF_*         - default opcodes and IDCODE value.
//   IR_CAPTURE    - value loaded into the IR LSBs in capture_ir.
package jtag_pkg;

  typedef enum logic [3:0] {
    tl_reset     = 4'd0,
    runtest_idle = 4'd1,
    select_dr    = 4'd2,
    capture_dr   = 4'd3,
    shift_dr     = 4'd4,
    exit1_dr     = 4'd5,
    pause_dr     = 4'd6,
    exit2_dr     = 4'd7,
    update_dr    = 4'd8,
    select_ir    = 4'd9,
    capture_ir   = 4'd10,
    shift_ir     = 4'd11,
    exit1_ir     = 4'd12,
    pause_ir     = 4'd13,
    exit2_ir     = 4'd14,
    update_ir    = 4'd15
  } tap_state_t;

  localparam logic [4:0]  DEF_IDCODE_INSTR = 5'h01;
  localparam logic [4:0]  DEF_USER_INSTR   = 5'h08;
  localparam logic [31:0] DEF_IDCODE_VALUE = 32'h1002_A0CB;
  localparam logic [1:0]  IR_CAPTURE       = 2'b01;

endpackage

// File: rtl/tap_state_fsm.sv
// tap_state_fsm: the 16-state TAP controller graph.
// Ports:
//   tck   - JTAG clock; state advances on the rising edge
//   trst  - asynchronous active-low reset, forces tl_reset
//   tms   - mode select that steers the graph
//   state - current TAP state
module tap_state_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_q, state_d;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_q <= tl_reset;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      tl_reset:     state_d = tms ? tl_reset  : runtest_idle;
      runtest_idle: state_d = tms ? select_dr : runtest_idle;
      select_dr:    state_d = tms ? select_ir : capture_dr;
      capture_dr:   state_d = tms ? exit1_dr  : shift_dr;
      shift_dr:     state_d = tms ? exit1_dr  : shift_dr;
      exit1_dr:     state_d = tms ? update_dr : pause_dr;
      pause_dr:     state_d = tms ? exit2_dr  : pause_dr;
      exit2_dr:     state_d = tms ? update_dr : shift_dr;
      update_dr:    state_d = tms ? select_dr : runtest_idle;
      select_ir:    state_d = tms ? tl_reset  : capture_ir;
      capture_ir:   state_d = tms ? exit1_ir  : shift_ir;
      shift_ir:     state_d = tms ? exit1_ir  : shift_ir;
      exit1_ir:     state_d = tms ? update_ir : pause_ir;
      pause_ir:     state_d = tms ? exit2_ir  : pause_ir;
      exit2_ir:     state_d = tms ? update_ir : shift_ir;
      update_ir:    state_d = tms ? select_dr : runtest_idle;
      default:      state_d = tl_reset;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_core.sv
// jtag_tap_core: a complete TAP. It contains the instruction register, the
// BYPASS and IDCODE data registers, and decoded strobes for one external
// USER chain.
// Ports:
//   tck, trst           - JTAG clock / async active-low reset
//   tms, tdi            - sampled on rising tck
//   tdo, tdo_en         - retimed on falling tck
//   state               - current TAP state
//   instr               - active (updated) instruction
//   user_sel            - instr selects the USER chain
//   user_capture/shift/update - USER chain strobes (combinational)
//   user_tdo            - serial output of the USER chain
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int                     IR_WIDTH     = 5,
  parameter logic [31:0]            IDCODE_VALUE = DEF_IDCODE_VALUE,
  parameter logic [IR_WIDTH-1:0]    IDCODE_INSTR = IR_WIDTH'(DEF_IDCODE_INSTR),
  parameter logic [IR_WIDTH-1:0]    USER_INSTR   = IR_WIDTH'(DEF_USER_INSTR)
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state,
  output logic [IR_WIDTH-1:0] instr,
  output logic                user_sel,
  output logic                user_capture,
  output logic                user_shift,
  output logic                user_update,
  input  logic                user_tdo
);

  tap_state_t fsm_state;

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                byp_q, byp_d;
  logic [31:0]         id_q, id_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                sel_idcode;

  tap_state_fsm u_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (fsm_state)
  );

  assign sel_idcode = (instr_q == IDCODE_INSTR);
  assign user_sel   = (instr_q == USER_INSTR);

  // Strobes are decoded directly from state, so they stay high for every
  // tck cycle spent in the corresponding state.
  assign user_capture = user_sel && (fsm_state == capture_dr);
  assign user_shift   = user_sel && (fsm_state == shift_dr);
  assign user_update  = user_sel && (fsm_state == update_dr);

  always_comb begin
    ir_d    = ir_q;
    instr_d = instr_q;
    byp_d   = byp_q;
    id_d    = id_q;
    case (fsm_state)
      // Only instr is forced here. The IR shift register keeps its contents.
      tl_reset:   instr_d = IDCODE_INSTR;
      capture_ir: ir_d    = IR_WIDTH'(IR_CAPTURE);
      shift_ir:   ir_d    = {tdi, ir_q[IR_WIDTH-1:1]};
      update_ir:  instr_d = ir_q;
      capture_dr: begin
        id_d  = IDCODE_VALUE;
        byp_d = 1'b0;
      end
      shift_dr: begin
        if (sel_idcode)     id_d  = {tdi, id_q[31:1]};
        else if (!user_sel) byp_d = tdi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_q    <= '0;
      instr_q <= IDCODE_INSTR;
      byp_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      ir_q    <= ir_d;
      instr_q <= instr_d;
      byp_q   <= byp_d;
      id_q    <= id_d;
    end
  end

  // The falling-edge retime gives the target half a cycle of hold margin.
  // It sees the state already entered at the preceding rising edge.
  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    if (fsm_state == shift_ir) begin
      tdo_d    = ir_q[0];
      tdo_en_d = 1'b1;
    end else if (fsm_state == shift_dr) begin
      tdo_d    = sel_idcode ? id_q[0] : (user_sel ? user_tdo : byp_q);
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo    = tdo_q;
  assign tdo_en = tdo_en_q;
  assign state  = fsm_state;
  assign instr  = instr_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
module tb_jtag_tap_core;
  localparam int          W   = 5;
  localparam logic [W-1:0] IDC = 5'h01;
  localparam logic [W-1:0] USR = 5'h08;
  localparam logic [31:0] IDV = 32'h1002_A0CB;

  logic tck = 1'b0, trst = 1'b1, tms = 1'b1, tdi = 1'b0, user_tdo = 1'b0;
  logic tdo, tdo_en, user_sel, user_capture, user_shift, user_update;
  logic [3:0]   state;
  logic [W-1:0] instr;

  always #5 tck = ~tck;

  jtag_tap_core dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .state(state), .instr(instr),
    .user_sel(user_sel), .user_capture(user_capture),
    .user_shift(user_shift), .user_update(user_update),
    .user_tdo(user_tdo)
  );

  // Successor tables of the 1149.1 graph, indexed by state number.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int n_cmp = 0, n_err = 0;

  // Reference model state
  int           m_state;
  logic [W-1:0] m_ir, m_instr;
  logic         m_byp, m_tdo, m_en;
  logic [31:0]  m_id;

  // TDO bits collected while the model says a shift state is active
  logic [31:0] shot;
  int          shot_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ir = '0; m_instr = IDC; m_byp = 1'b0;
    m_id = '0; m_tdo = 1'b0; m_en = 1'b0;
  endtask

  // Called at negedge+1; returns at the following negedge+1.
  task automatic step(input logic t_ms, input logic t_di);
    tms = t_ms; tdi = t_di; user_tdo = 1'($urandom_range(0, 1));
    @(posedge tck); #1;
    if (m_state == 0)  m_instr = IDC;
    if (m_state == 10) m_ir = W'(1);
    if (m_state == 11) m_ir = (m_ir >> 1) | (W'(t_di) << (W - 1));
    if (m_state == 15) m_instr = m_ir;
    if (m_state == 3) begin m_id = IDV; m_byp = 1'b0; end
    if (m_state == 4) begin
      if (m_instr == IDC)      m_id = (m_id >> 1) | (32'(t_di) << 31);
      else if (m_instr != USR) m_byp = t_di;
    end
    m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
    @(negedge tck); #1;
    if (m_state == 11) begin
      m_tdo = m_ir[0]; m_en = 1'b1;
    end else if (m_state == 4) begin
      m_tdo = (m_instr == IDC) ? m_id[0] : (m_instr == USR) ? user_tdo : m_byp;
      m_en = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("instr", 32'(instr), 32'(m_instr));
    check_eq("tdo_en", 32'(tdo_en), 32'(m_en));
    check_eq("tdo", 32'(tdo), 32'(m_tdo));
    check_eq("user_sel", 32'(user_sel), 32'(m_instr == USR));
    check_eq("user_capture", 32'(user_capture), 32'(m_instr == USR && m_state == 3));
    check_eq("user_shift", 32'(user_shift), 32'(m_instr == USR && m_state == 4));
    check_eq("user_update", 32'(user_update), 32'(m_instr == USR && m_state == 8));
    if (m_en && shot_n < 32) begin
      shot = shot | (32'(tdo) << shot_n);
      shot_n++;
    end
  endtask

  task automatic reset_to_idle();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From runtest_idle, ends in runtest_idle.
  task automatic load_ir(input logic [W-1:0] op);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    shot = '0; shot_n = 0;
    step(1'b0, 1'b0);
    for (int i = 0; i < W; i++) step(i == W - 1, op[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    $display("IR load %0h -> instr %0h", op, instr);
  endtask

  // From runtest_idle, ends in runtest_idle. Shifts n bits of 'bits' LSB first.
  task automatic dr_scan(input int n, input logic [63:0] bits);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    shot = '0; shot_n = 0;
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(i == n - 1, bits[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    $display("DR scan instr %0h len %0d tdo %0h", instr, n, shot);
  endtask

  initial begin
    logic [W-1:0] ops [5];
    int r;
    shot = '0; shot_n = 0;
    model_reset();

    // Power-on reset
    #1 trst = 1'b0;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_instr", 32'(instr), 32'(IDC));
    check_eq("rst_tdo", 32'(tdo), 32'd0);
    check_eq("rst_tdo_en", 32'(tdo_en), 32'd0);
    @(negedge tck); #1 trst = 1'b1;

    // IDCODE read straight after reset: TMS 0,1,0,0 then 32 shifts
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    shot = '0; shot_n = 0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(i == 31, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    check_eq("idcode_read", shot, IDV);
    $display("IDCODE read %0h", shot);

    // BYPASS via all-ones opcode
    load_ir(5'h1F);
    check_eq("ir_capture", 32'(shot[4:0]), 32'h01);
    check_eq("instr_1f", 32'(instr), 32'h1F);
    dr_scan(4, 64'b1101);
    check_eq("bypass_1f", 32'(shot[3:0]), 32'b1010);

    // USER chain
    load_ir(USR);
    check_eq("user_sel_on", 32'(user_sel), 32'd1);
    dr_scan(6, {$urandom, $urandom});

    // Unlisted opcode behaves as BYPASS
    load_ir(5'h05);
    dr_scan(4, 64'b1101);
    check_eq("bypass_05", 32'(shot[3:0]), 32'b1010);

    // From pause_ir, five TMS=1 reach tl_reset
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_eq("in_pause_ir", 32'(state), 32'd13);
    repeat (5) step(1'b1, 1'b0);
    check_eq("pause_ir_tlr", 32'(state), 32'd0);
    step(1'b1, 1'b0);
    check_eq("tlr_instr", 32'(instr), 32'(IDC));
    step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a USER DR scan
    load_ir(USR);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
    #1 trst = 1'b0;
    #1;
    check_eq("async_state", 32'(state), 32'd0);
    check_eq("async_instr", 32'(instr), 32'(IDC));
    check_eq("async_tdo_en", 32'(tdo_en), 32'd0);
    check_eq("async_tdo", 32'(tdo), 32'd0);
    model_reset();
    @(negedge tck); #1 trst = 1'b1;
    step(1'b0, 1'b0);

    // Randomised traffic
    ops[0] = 5'h01; ops[1] = 5'h08; ops[2] = 5'h1F; ops[3] = 5'h05;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 2);
      ops[4] = W'($urandom);
      case (r)
        0: load_ir(ops[$urandom_range(0, 4)]);
        1: dr_scan($urandom_range(1, 40), {$urandom, $urandom});
        default: begin
          repeat (8) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          reset_to_idle();
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
